// File: rtl/addr_adder_arbiter_if.sv
// Request/response bundle for the shared-adder arbiter: NUM_REQ packed
// requesters on one side, a single registered result on the other.
interface addr_adder_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 2
);
   localparam int NUM_REQ = 2 ** ID_WIDTH;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data0;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data1;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          rsp_valid;
   logic                          rsp_ready;
   logic [ID_WIDTH-1:0]           rsp_id;
   logic [DATA_WIDTH-1:0]         rsp_sum;

   modport master (
      output req_valid, req_data0, req_data1, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum
   );

   modport slave (
      input  req_valid, req_data0, req_data1, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum
   );
endinterface

// File: rtl/addr_adder_arbiter.sv
// Round-robin arbiter feeding one shared adder; the winner's sum lands in a
// single-entry result register that drains through a valid/ready handshake.
module addr_adder_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 2
) (
   input logic                clk,
   input logic                rst_n,
   addr_adder_arbiter_if.slave bus
);
   localparam int NUM_REQ = 2 ** ID_WIDTH;

   typedef enum logic {EMPTY, FULL} state_e;

   state_e                state_q, state_d;
   logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
   logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
   logic [DATA_WIDTH-1:0] rsp_sum_q, rsp_sum_d;

   logic [DATA_WIDTH-1:0] data0Arr [NUM_REQ];
   logic [DATA_WIDTH-1:0] data1Arr [NUM_REQ];
   logic                  winnerFound;
   logic [ID_WIDTH-1:0]   winnerIdx;
   logic                  canAccept;
   logic                  grant;
   logic [DATA_WIDTH-1:0] opA, opB, adderSum;

   for (genvar g = 0; g < NUM_REQ; g++) begin : gUnpack
      assign data0Arr[g] = bus.req_data0[g*DATA_WIDTH +: DATA_WIDTH];
      assign data1Arr[g] = bus.req_data1[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Scan from ptr upward with natural ID_WIDTH wrap; first valid requester wins.
   always_comb begin
      logic [ID_WIDTH-1:0] scanIdx;
      winnerFound = 1'b0;
      winnerIdx   = '0;
      scanIdx     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scanIdx = ptr_q + ID_WIDTH'(k);
         if (!winnerFound && bus.req_valid[scanIdx]) begin
            winnerFound = 1'b1;
            winnerIdx   = scanIdx;
         end
      end
   end

   // rst_n gates acceptance so req_ready stays low throughout reset.
   assign canAccept = rst_n && ((state_q == EMPTY) || bus.rsp_ready);
   assign grant     = winnerFound && canAccept;

   assign bus.req_ready = grant ? (NUM_REQ'(1) << winnerIdx) : '0;

   assign opA      = data0Arr[winnerIdx];
   assign opB      = data1Arr[winnerIdx];
   assign adderSum = opA + opB;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rsp_id_d  = rsp_id_q;
      rsp_sum_d = rsp_sum_q;
      if (grant) begin
         state_d   = FULL;
         rsp_sum_d = adderSum;
         rsp_id_d  = winnerIdx;
         ptr_d     = winnerIdx + ID_WIDTH'(1);
      end else if ((state_q == FULL) && bus.rsp_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         ptr_q     <= '0;
         rsp_id_q  <= '0;
         rsp_sum_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         rsp_id_q  <= rsp_id_d;
         rsp_sum_q <= rsp_sum_d;
      end
   end

   assign bus.rsp_valid = (state_q == FULL);
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_sum   = rsp_sum_q;
endmodule

// File: tb/tb_addr_adder_arbiter.sv
// Directed bench for addr_adder_arbiter: reset, single request, round-robin,
// backpressure, modulo wrap, pointer hold and mid-operation reset.
module tb_addr_adder_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   logic [31:0] d0 [4];
   logic [31:0] d1 [4];
   int          rrGrant [5] = '{1, 2, 3, 0, 1};
   logic [31:0] rrSum   [4] = '{32'h0000_0001, 32'h0000_0102, 32'h0000_0203, 32'h0000_0304};

   addr_adder_arbiter_if #(.DATA_WIDTH(32), .ID_WIDTH(2)) bus ();

   addr_adder_arbiter #(.DATA_WIDTH(32), .ID_WIDTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [3:0] valid, input logic rspReady);
      bus.req_valid = valid;
      bus.rsp_ready = rspReady;
      for (int i = 0; i < 4; i++) begin
         bus.req_data0[i*32 +: 32] = d0[i];
         bus.req_data1[i*32 +: 32] = d1[i];
      end
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      $display("[TB] starting addr_adder_arbiter directed test");
      for (int i = 0; i < 4; i++) begin
         d0[i] = '0;
         d1[i] = '0;
      end
      rst_n = 1'b0;
      applyStimulus(4'b1111, 1'b1);
      #3;
      checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
      checkOutput("reset_rsp_sum",   bus.rsp_sum,   0);
      checkOutput("reset_rsp_id",    bus.rsp_id,    0);
      checkOutput("reset_req_ready", bus.req_ready, 0);
      tick();
      rst_n = 1'b1;

      // Single request from requester 0
      d0[0] = 32'h0000_1000;
      d1[0] = 32'h0000_0004;
      applyStimulus(4'b0001, 1'b1);
      #1;
      checkOutput("single_req_ready", bus.req_ready, 4'b0001);
      tick();
      applyStimulus(4'b0000, 1'b1);
      checkOutput("single_rsp_valid", bus.rsp_valid, 1);
      checkOutput("single_rsp_id",    bus.rsp_id,    0);
      checkOutput("single_rsp_sum",   bus.rsp_sum,   32'h0000_1004);

      // FULL, consumer ready, no transfer: drains, sum retained
      tick();
      checkOutput("drain_rsp_valid", bus.rsp_valid, 0);
      checkOutput("drain_rsp_sum",   bus.rsp_sum,   32'h0000_1004);

      // Round robin with all requesters valid; pointer is 1 here
      for (int i = 0; i < 4; i++) begin
         d0[i] = 32'(i * 32'h100);
         d1[i] = 32'(i + 1);
      end
      for (int s = 0; s < 5; s++) begin
         applyStimulus(4'b1111, 1'b1);
         #1;
         checkOutput($sformatf("rr_req_ready_%0d", s), bus.req_ready, 64'(4'b0001 << rrGrant[s]));
         tick();
         checkOutput($sformatf("rr_rsp_id_%0d", s),  bus.rsp_id,  64'(rrGrant[s]));
         checkOutput($sformatf("rr_rsp_sum_%0d", s), bus.rsp_sum, rrSum[rrGrant[s]]);
      end

      // Backpressure: held result id1/0x102, requester 1 waits
      d0[1] = 32'h0000_5000;
      d1[1] = 32'h0000_0007;
      applyStimulus(4'b0010, 1'b0);
      for (int s = 0; s < 5; s++) begin
         #1;
         checkOutput($sformatf("bp_req_ready_%0d", s), bus.req_ready, 0);
         tick();
         checkOutput($sformatf("bp_rsp_valid_%0d", s), bus.rsp_valid, 1);
         checkOutput($sformatf("bp_rsp_id_%0d", s),    bus.rsp_id,    1);
         checkOutput($sformatf("bp_rsp_sum_%0d", s),   bus.rsp_sum,   32'h0000_0102);
      end
      applyStimulus(4'b0010, 1'b1);
      #1;
      checkOutput("bp_release_req_ready", bus.req_ready, 4'b0010);
      tick();
      checkOutput("bp_release_rsp_id",  bus.rsp_id,  1);
      checkOutput("bp_release_rsp_sum", bus.rsp_sum, 32'h0000_5007);

      // Modulo wrap and pointer wrap after granting requester 3 (ptr is 2)
      d0[3] = 32'hFFFF_FFFF;
      d1[3] = 32'h0000_0002;
      applyStimulus(4'b1000, 1'b1);
      #1;
      checkOutput("wrap_req_ready", bus.req_ready, 4'b1000);
      tick();
      checkOutput("wrap_rsp_sum", bus.rsp_sum, 32'h0000_0001);
      checkOutput("wrap_rsp_id",  bus.rsp_id,  3);
      applyStimulus(4'b1111, 1'b1);
      #1;
      checkOutput("ptrwrap_req_ready", bus.req_ready, 4'b0001);
      tick();
      checkOutput("ptrwrap_rsp_id",  bus.rsp_id,  0);
      checkOutput("ptrwrap_rsp_sum", bus.rsp_sum, 32'h0000_0001);

      // Idle cycle must not move the pointer (stays 1)
      applyStimulus(4'b0000, 1'b1);
      tick();
      checkOutput("idle_rsp_valid", bus.rsp_valid, 0);
      applyStimulus(4'b1101, 1'b1);
      #1;
      checkOutput("hold_ptr_req_ready", bus.req_ready, 4'b0100);
      tick();
      checkOutput("hold_ptr_rsp_id",  bus.rsp_id,  2);
      checkOutput("hold_ptr_rsp_sum", bus.rsp_sum, 32'h0000_0203);

      // Asynchronous reset between edges with a result held
      applyStimulus(4'b0000, 1'b0);
      checkOutput("prereset_rsp_valid", bus.rsp_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_rsp_valid", bus.rsp_valid, 0);
      checkOutput("midreset_rsp_sum",   bus.rsp_sum,   0);
      checkOutput("midreset_rsp_id",    bus.rsp_id,    0);
      applyStimulus(4'b0100, 1'b1);
      #1;
      checkOutput("midreset_req_ready", bus.req_ready, 0);
      tick();
      checkOutput("inreset_rsp_valid", bus.rsp_valid, 0);
      rst_n = 1'b1;
      #1;
      checkOutput("postreset_req_ready", bus.req_ready, 4'b0100);
      tick();
      applyStimulus(4'b0000, 1'b1);
      checkOutput("postreset_rsp_valid", bus.rsp_valid, 1);
      checkOutput("postreset_rsp_id",    bus.rsp_id,    2);
      checkOutput("postreset_rsp_sum",   bus.rsp_sum,   32'h0000_0203);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/addr_adder_arbiter.md
ADDR_ADDER_ARBITER -- requirements
Module: addr_adder_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of addends and sum.
REQ-002 Parameter ID_WIDTH, default 2, requester index width; NUM_REQ = 2**ID_WIDTH requesters (4 by default).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester request strobe, bit i = requester i.
REQ-006 req_data0  input  NUM_REQ*DATA_WIDTH  first addend; requester i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 req_data1  input  NUM_REQ*DATA_WIDTH  second addend, same packing as req_data0.
REQ-008 req_ready  output  NUM_REQ  one-hot-or-zero grant; transfer on requester i when req_valid[i] & req_ready[i].
REQ-009 rsp_valid  output  1  result register holds a valid sum.
REQ-010 rsp_ready  input  1  consumer accepts result when rsp_valid & rsp_ready.
REQ-011 rsp_id  output  ID_WIDTH  index of requester whose sum is in rsp_sum.
REQ-012 rsp_sum  output  DATA_WIDTH  registered sum.

Function
REQ-013 Block SHALL share one DATA_WIDTH adder instance (data0 + data1 -> sum) among all requesters; only the granted requester's operands reach it.
REQ-014 Sum SHALL be modulo 2**DATA_WIDTH; carry-out discarded, no overflow flag.
REQ-015 States: EMPTY (rsp_valid=0) and FULL (rsp_valid=1); single-entry result register.
REQ-016 can_accept SHALL be 1 in EMPTY, and in FULL only when rsp_ready=1 in the same cycle.
REQ-017 Grant SHALL be round-robin: search starts at pointer ptr, scanning ptr, ptr+1, ... wrapping mod NUM_REQ; first requester with req_valid=1 wins.
REQ-018 req_ready SHALL be combinational: bit of the winner set only when can_accept=1; all bits 0 otherwise or when no req_valid bit is set.
REQ-019 req_ready SHALL never have more than one bit set and SHALL never be set for a requester with req_valid=0.
REQ-020 On a transfer, at the next edge: rsp_sum <= winner data0+data1, rsp_id <= winner index, rsp_valid <= 1, ptr <= (winner+1) mod NUM_REQ.
REQ-021 Latency: result visible on rsp_* exactly one cycle after the transfer cycle.
REQ-022 Throughput: one transfer per cycle sustained while rsp_ready=1 (FULL with rsp_ready=1 and a transfer -> stays FULL, new data loaded).
REQ-023 FULL with rsp_ready=1 and no transfer -> EMPTY, rsp_valid <= 0; rsp_sum/rsp_id retain last values.
REQ-024 FULL with rsp_ready=0 -> hold rsp_valid, rsp_sum, rsp_id stable; req_ready all 0.
REQ-025 ptr SHALL change only on a transfer; no transfer leaves ptr unchanged.
REQ-026 Pointer wrap: winner NUM_REQ-1 -> ptr 0.
REQ-027 Requester i held valid while another is granted SHALL be granted within NUM_REQ transfers (starvation-free).
REQ-028 Block SHALL not require req_valid to stay asserted after a denied cycle; request withdrawal before grant is legal and has no effect.

Reset
REQ-029 While rst_n=0: rsp_valid=0, rsp_sum=0, rsp_id=0, ptr=0, state EMPTY, req_ready all 0, asynchronously and independent of clk.
REQ-030 Reset asserted mid-operation SHALL discard any held result; no response for it after release.
REQ-031 First edge after rst_n rises SHALL allow a transfer (req_ready may assert in the first cycle after release).

Verification
REQ-032 Single request: req_valid=0001, data0=0x1000, data1=0x0004 -> req_ready=0001; next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x00001004.
REQ-033 Round-robin: req_valid=1111 held, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; rsp_id sequence 0,1,2,3,0 one cycle later.
REQ-034 Backpressure: result pending, rsp_ready=0 for 5 cycles with req_valid=0010 -> req_ready=0000, rsp_* stable; rsp_ready=1 -> same-cycle grant to 1, its sum next cycle.
REQ-035 Wrap: data0=0xFFFFFFFF, data1=0x00000002 -> rsp_sum=0x00000001; ptr after grant of requester 3 -> next grant scan starts at 0.
REQ-036 Reset mid-operation: rsp_valid=1, pull rst_n low between edges -> rsp_valid=0, rsp_sum=0 immediately; after release req_valid=0100 -> rsp_id=2 one cycle after grant.
REQ-037 Random bench: constrained-random req_valid/rsp_ready over 10k cycles -> every response equals scoreboard sum mod 2**32, req_ready one-hot-or-zero, no requester waits more than NUM_REQ transfers.
